// File: rtl/ram_sdp_arbiter.sv
// Round-robin sharing of one simple-dual-port RAM among NUM_CLIENTS requesters.
// Independent read/write arbitration, tagged read return, zero-fill sweep after reset/clear.
module ram_sdp_arbiter #(
    parameter int unsigned NUM_CLIENTS  = 2,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                                                clk,
    input  logic                                                resetn,
    input  logic                                                clear,
    output logic                                                init_busy,
    input  logic [NUM_CLIENTS-1:0]                              req_valid,
    input  logic [NUM_CLIENTS-1:0]                              req_we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]                   req_addr,
    input  logic [NUM_CLIENTS*(DATA_WIDTH/BYTE_WIDTH)-1:0]      req_strobe,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]                   req_wdata,
    output logic [NUM_CLIENTS-1:0]                              req_ready,
    output logic [NUM_CLIENTS-1:0]                              resp_valid,
    output logic [DATA_WIDTH-1:0]                               resp_data,
    output logic                                                ram_en,
    output logic [ADDR_WIDTH-1:0]                               ram_waddr,
    output logic [(DATA_WIDTH/BYTE_WIDTH)-1:0]                  ram_strobe,
    output logic [DATA_WIDTH-1:0]                               ram_wdata,
    output logic [ADDR_WIDTH-1:0]                               ram_raddr,
    input  logic [DATA_WIDTH-1:0]                               ram_rdata
);

    localparam int unsigned BPW   = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned PW1   = PTR_W + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NUM_CLIENTS-1:0] wr_cand, rd_cand, wr_gnt, rd_gnt;
    logic [PTR_W:0]         wr_pick, rd_pick;
    logic                   wr_any, rd_any;
    logic [PTR_W-1:0]       wr_idx, rd_idx;
    logic [ADDR_WIDTH-1:0]  raddr_q;

    logic [ADDR_WIDTH-1:0] addr_a   [NUM_CLIENTS];
    logic [BPW-1:0]        strobe_a [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0] wdata_a  [NUM_CLIENTS];

    // Unpack the flat client buses
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign addr_a[i]   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign strobe_a[i] = req_strobe[i*BPW +: BPW];
        assign wdata_a[i]  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First candidate at or after ptr, wrapping; returns {found, index}
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_CLIENTS-1:0] cand,
                                               input logic [PTR_W-1:0] ptr);
        logic [2*NUM_CLIENTS-1:0] dbl;
        logic [PTR_W:0]           pos;
        logic                     found;
        logic [PTR_W-1:0]         idx;
        dbl   = {cand, cand} >> ptr;
        pos   = '0;
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < NUM_CLIENTS; j++) begin
            if (!found && dbl[j]) begin
                pos = {1'b0, ptr} + PW1'(j);
                if (pos >= PW1'(NUM_CLIENTS)) pos = pos - PW1'(NUM_CLIENTS);
                found = 1'b1;
                idx   = pos[PTR_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W:0] n;
        n = {1'b0, p} + PW1'(1);
        if (n >= PW1'(NUM_CLIENTS)) n = '0;
        return n[PTR_W-1:0];
    endfunction

    // State and sweep counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) state_d = ST_RUN;
            end
            default: ;
        endcase
        if (clear) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end
    end

    assign init_busy = (state_q == ST_INIT);

    // Independent read and write round-robin arbiters
    always_comb begin
        wr_cand  = (state_q == ST_RUN) ? (req_valid &  req_we) : '0;
        rd_cand  = (state_q == ST_RUN) ? (req_valid & ~req_we) : '0;
        wr_pick  = rr_pick(wr_cand, wr_ptr_q);
        rd_pick  = rr_pick(rd_cand, rd_ptr_q);
        wr_any   = wr_pick[PTR_W];
        wr_idx   = wr_pick[PTR_W-1:0];
        rd_any   = rd_pick[PTR_W];
        rd_idx   = rd_pick[PTR_W-1:0];
        wr_gnt   = wr_any ? (NUM_CLIENTS'(1) << wr_idx) : '0;
        rd_gnt   = rd_any ? (NUM_CLIENTS'(1) << rd_idx) : '0;
        wr_ptr_d = wr_any ? ptr_inc(wr_idx) : wr_ptr_q;
        rd_ptr_d = rd_any ? ptr_inc(rd_idx) : rd_ptr_q;
    end

    assign req_ready = wr_gnt | rd_gnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            raddr_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            raddr_q  <= ram_raddr;
        end
    end

    // Write port: sweep owns it in INIT, held at zero while reset is asserted
    always_comb begin
        ram_en     = 1'b0;
        ram_waddr  = '0;
        ram_strobe = '0;
        ram_wdata  = '0;
        if (state_q == ST_INIT) begin
            if (resetn) begin
                ram_en     = 1'b1;
                ram_waddr  = cnt_q;
                ram_strobe = '1;
            end
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (wr_gnt[i]) begin
                    ram_en     = 1'b1;
                    ram_waddr  = addr_a[i];
                    ram_strobe = strobe_a[i];
                    ram_wdata  = wdata_a[i];
                end
            end
        end
    end

    // Read address holds its last value when no read is granted
    always_comb begin
        ram_raddr = raddr_q;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (rd_gnt[i]) ram_raddr = addr_a[i];
        end
    end

    assign resp_data = ram_rdata;

    if (READ_LATENCY == 0) begin : g_lat0
        assign resp_valid = rd_gnt;
    end else begin : g_latn
        logic [READ_LATENCY-1:0] tag_v_q;
        logic [PTR_W-1:0]        tag_idx_q [READ_LATENCY];

        // Tag shift register tracking reads through the RAM pipeline
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                tag_v_q <= '0;
                for (int k = 0; k < READ_LATENCY; k++) tag_idx_q[k] <= '0;
            end else begin
                tag_v_q[0]   <= rd_any;
                tag_idx_q[0] <= rd_idx;
                for (int k = 1; k < READ_LATENCY; k++) begin
                    tag_v_q[k]   <= tag_v_q[k-1];
                    tag_idx_q[k] <= tag_idx_q[k-1];
                end
            end
        end

        assign resp_valid = tag_v_q[READ_LATENCY-1] ?
                            (NUM_CLIENTS'(1) << tag_idx_q[READ_LATENCY-1]) : '0;
    end

endmodule

// File: tb/tb_ram_sdp_arbiter.sv
// Directed bench for ram_sdp_arbiter: 2 clients, 16-word RAM, read latency 2.
// A behavioural read-first byte-masked RAM is attached to the RAM ports.
module tb_ram_sdp_arbiter;

    localparam int unsigned NC  = 2;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 64;
    localparam int unsigned BW  = 8;
    localparam int unsigned RL  = 2;
    localparam int unsigned BPW = DW / BW;

    logic                clk;
    logic                resetn;
    logic                clear;
    logic                init_busy;
    logic [NC-1:0]       req_valid;
    logic [NC-1:0]       req_we;
    logic [NC*AW-1:0]    req_addr;
    logic [NC*BPW-1:0]   req_strobe;
    logic [NC*DW-1:0]    req_wdata;
    logic [NC-1:0]       req_ready;
    logic [NC-1:0]       resp_valid;
    logic [DW-1:0]       resp_data;
    logic                ram_en;
    logic [AW-1:0]       ram_waddr;
    logic [BPW-1:0]      ram_strobe;
    logic [DW-1:0]       ram_wdata;
    logic [AW-1:0]       ram_raddr;
    logic [DW-1:0]       ram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    ram_sdp_arbiter #(
        .NUM_CLIENTS (NC),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BYTE_WIDTH  (BW),
        .READ_LATENCY(RL)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .init_busy (init_busy),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_strobe(req_strobe),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .ram_en    (ram_en),
        .ram_waddr (ram_waddr),
        .ram_strobe(ram_strobe),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Attached RAM: read-first, byte-masked writes, two-stage read pipeline
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_s1;
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < BPW; b++) begin
                if (ram_strobe[b]) mem[ram_waddr][b*BW +: BW] <= ram_wdata[b*BW +: BW];
            end
        end
        rd_s1     <= mem[ram_raddr];
        ram_rdata <= rd_s1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                              input logic [BPW-1:0] s, input logic [DW-1:0] d);
        req_valid[i]             = v;
        req_we[i]                = we;
        req_addr[i*AW +: AW]     = a;
        req_strobe[i*BPW +: BPW] = s;
        req_wdata[i*DW +: DW]    = d;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic test_reset();
        logic ok;
        repeat (2) @(posedge clk);
        #1;
        set_client(0, 1'b1, 1'b0, 4'd0, 8'h00, 64'h0);
        set_client(1, 1'b1, 1'b0, 4'd1, 8'h00, 64'h0);
        #1;
        n_cmp++;
        if (init_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", init_busy); end
        n_cmp++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
            n_err++; $display("FAIL reset_hs: ready %b resp %b expected 00 00", req_ready, resp_valid);
        end
        n_cmp++;
        if (ram_en !== 1'b0 || ram_waddr !== 4'd0 || ram_raddr !== 4'd0 || ram_strobe !== 8'h00) begin
            n_err++; $display("FAIL reset_ram: en %b waddr %0d raddr %0d strobe %h expected all 0",
                              ram_en, ram_waddr, ram_raddr, ram_strobe);
        end
        resetn = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            ok = (init_busy === 1'b1) && (ram_en === 1'b1) && (ram_waddr === AW'(c)) &&
                 (ram_wdata === 64'h0) && (ram_strobe === 8'hFF) && (req_ready === 2'b00);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL sweep_%0d: busy %b en %b waddr %0d wdata %h strobe %h ready %b expected 1 1 %0d 0 ff 00",
                         c, init_busy, ram_en, ram_waddr, ram_wdata, ram_strobe, req_ready, c);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (init_busy !== 1'b0) begin n_err++; $display("FAIL sweep_end: busy %b expected 0", init_busy); end
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL first_grant: got %b expected 01", req_ready); end
        tick();
        idle_all();
        #1;
        n_cmp++;
        if (resp_valid !== 2'b00) begin n_err++; $display("FAIL first_lat1: got %b expected 00", resp_valid); end
        tick();
        n_cmp++;
        if (resp_valid !== 2'b01 || resp_data !== 64'h0) begin
            n_err++; $display("FAIL first_resp: valid %b data %h expected 01 0", resp_valid, resp_data);
        end
        tick();
    endtask

    task automatic test_write_read();
        set_client(0, 1'b1, 1'b1, 4'd3, 8'hFF, 64'hDEAD_BEEF);
        #1;
        n_cmp++;
        if (req_ready !== 2'b01 || ram_en !== 1'b1 || ram_waddr !== 4'd3 ||
            ram_wdata !== 64'hDEAD_BEEF || ram_strobe !== 8'hFF) begin
            n_err++; $display("FAIL wr_issue: ready %b en %b waddr %0d wdata %h strobe %h expected 01 1 3 deadbeef ff",
                              req_ready, ram_en, ram_waddr, ram_wdata, ram_strobe);
        end
        tick();
        set_client(0, 1'b1, 1'b0, 4'd3, 8'h00, 64'h0);
        #1;
        n_cmp++;
        if (req_ready !== 2'b01 || ram_en !== 1'b0 || ram_raddr !== 4'd3) begin
            n_err++; $display("FAIL rd_issue: ready %b en %b raddr %0d expected 01 0 3", req_ready, ram_en, ram_raddr);
        end
        tick();
        idle_all();
        #1;
        n_cmp++;
        if (resp_valid !== 2'b00 || ram_raddr !== 4'd3) begin
            n_err++; $display("FAIL rd_wait: resp %b raddr %0d expected 00 3", resp_valid, ram_raddr);
        end
        tick();
        n_cmp++;
        if (resp_valid !== 2'b01 || resp_data !== 64'hDEAD_BEEF) begin
            n_err++; $display("FAIL rd_resp: valid %b data %h expected 01 deadbeef", resp_valid, resp_data);
        end
        tick();
        n_cmp++;
        if (resp_valid !== 2'b00) begin n_err++; $display("FAIL rd_done: got %b expected 00", resp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        logic [DW-1:0] exp_d;
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                set_client(0, 1'b1, 1'b0, 4'd3, 8'h00, 64'h0);
                set_client(1, 1'b1, 1'b0, 4'd5, 8'h00, 64'h0);
            end else begin
                idle_all();
            end
            #1;
            if (k < 4) begin
                n_cmp++;
                if (req_ready !== exp_g[k]) begin
                    n_err++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp_g[k]);
                end
            end
            if (k >= 2) begin
                exp_d = (exp_g[k-2] == 2'b01) ? 64'hDEAD_BEEF : 64'h0;
                n_cmp++;
                if (resp_valid !== exp_g[k-2] || resp_data !== exp_d) begin
                    n_err++; $display("FAIL rr_resp_%0d: valid %b data %h expected %b %h",
                                      k, resp_valid, resp_data, exp_g[k-2], exp_d);
                end
            end
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                set_client(0, 1'b1, 1'b0, 4'd3, 8'h00, 64'h0);
                set_client(1, 1'b1, 1'b1, 4'd9, 8'hFF, 64'h100 + 64'(k));
            end else begin
                idle_all();
            end
            #1;
            if (k < 4) begin
                n_cmp++;
                if (req_ready !== 2'b11 || ram_en !== 1'b1 || ram_waddr !== 4'd9 ||
                    ram_wdata !== 64'h100 + 64'(k) || ram_raddr !== 4'd3) begin
                    n_err++; $display("FAIL par_%0d: ready %b en %b waddr %0d wdata %h raddr %0d expected 11 1 9 %h 3",
                                      k, req_ready, ram_en, ram_waddr, ram_wdata, ram_raddr, 64'h100 + 64'(k));
                end
            end
            if (k >= 2) begin
                n_cmp++;
                if (resp_valid !== 2'b01 || resp_data !== 64'hDEAD_BEEF) begin
                    n_err++; $display("FAIL par_resp_%0d: valid %b data %h expected 01 deadbeef",
                                      k, resp_valid, resp_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_read_first();
        set_client(0, 1'b1, 1'b1, 4'd7, 8'hFF, 64'h11);
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL rf_pre: got %b expected 01", req_ready); end
        tick();
        set_client(0, 1'b1, 1'b1, 4'd7, 8'hFF, 64'h55);
        set_client(1, 1'b1, 1'b0, 4'd7, 8'h00, 64'h0);
        #1;
        n_cmp++;
        if (req_ready !== 2'b11) begin n_err++; $display("FAIL rf_same: got %b expected 11", req_ready); end
        tick();
        set_client(0, 1'b0, 1'b0, 4'd0, 8'h00, 64'h0);
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin n_err++; $display("FAIL rf_reread: got %b expected 10", req_ready); end
        tick();
        idle_all();
        #1;
        n_cmp++;
        if (resp_valid !== 2'b10 || resp_data !== 64'h11) begin
            n_err++; $display("FAIL rf_old: valid %b data %h expected 10 11", resp_valid, resp_data);
        end
        tick();
        n_cmp++;
        if (resp_valid !== 2'b10 || resp_data !== 64'h55) begin
            n_err++; $display("FAIL rf_new: valid %b data %h expected 10 55", resp_valid, resp_data);
        end
        tick();
    endtask

    task automatic test_strobe();
        set_client(0, 1'b1, 1'b1, 4'd12, 8'hFF, '1);
        tick();
        set_client(0, 1'b1, 1'b1, 4'd12, 8'h01, 64'h0);
        #1;
        n_cmp++;
        if (ram_strobe !== 8'h01 || ram_wdata !== 64'h0 || ram_waddr !== 4'd12) begin
            n_err++; $display("FAIL strobe_pass: strobe %h wdata %h waddr %0d expected 01 0 12",
                              ram_strobe, ram_wdata, ram_waddr);
        end
        tick();
        set_client(0, 1'b1, 1'b0, 4'd12, 8'h00, 64'h0);
        tick();
        idle_all();
        tick();
        n_cmp++;
        if (resp_valid !== 2'b01 || resp_data !== 64'hFFFF_FFFF_FFFF_FF00) begin
            n_err++; $display("FAIL strobe_rd: valid %b data %h expected 01 ffffffffffffff00", resp_valid, resp_data);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        int  n;
        logic bad;
        set_client(0, 1'b1, 1'b0, 4'd3, 8'h00, 64'h0);
        tick();
        idle_all();
        #1;
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (init_busy !== 1'b1 || ram_waddr !== 4'd0 || resp_valid !== 2'b00) begin
            n_err++; $display("FAIL rst_restart: busy %b waddr %0d resp %b expected 1 0 00",
                              init_busy, ram_waddr, resp_valid);
        end
        tick();
        n_cmp++;
        if (resp_valid !== 2'b00 || ram_waddr !== 4'd1) begin
            n_err++; $display("FAIL rst_drop: resp %b waddr %0d expected 00 1", resp_valid, ram_waddr);
        end
        n   = 0;
        bad = 1'b0;
        while (init_busy === 1'b1 && n < 40) begin
            if (resp_valid !== 2'b00) bad = 1'b1;
            n++;
            tick();
        end
        n_cmp++;
        if (n != 15 || bad) begin
            n_err++; $display("FAIL rst_sweep: busy cycles %0d stray resp %b expected 15 0", n, bad);
        end
    endtask

    task automatic test_clear_inflight();
        int n;
        set_client(0, 1'b1, 1'b1, 4'd2, 8'hFF, 64'hABCD);
        tick();
        set_client(0, 1'b1, 1'b0, 4'd2, 8'h00, 64'h0);
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL clr_issue: got %b expected 01", req_ready); end
        tick();
        idle_all();
        clear = 1'b1;
        #1;
        n_cmp++;
        if (init_busy !== 1'b0) begin n_err++; $display("FAIL clr_cycle: busy %b expected 0", init_busy); end
        tick();
        clear = 1'b0;
        n_cmp++;
        if (init_busy !== 1'b1 || ram_waddr !== 4'd0 || resp_valid !== 2'b01 || resp_data !== 64'hABCD) begin
            n_err++; $display("FAIL clr_resp: busy %b waddr %0d valid %b data %h expected 1 0 01 abcd",
                              init_busy, ram_waddr, resp_valid, resp_data);
        end
        tick();
        n_cmp++;
        if (ram_waddr !== 4'd1 || resp_valid !== 2'b00) begin
            n_err++; $display("FAIL clr_next: waddr %0d resp %b expected 1 00", ram_waddr, resp_valid);
        end
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (ram_waddr !== 4'd0 || init_busy !== 1'b1) begin
            n_err++; $display("FAIL clr_restart: waddr %0d busy %b expected 0 1", ram_waddr, init_busy);
        end
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n != 16) begin n_err++; $display("FAIL clr_sweep: busy cycles %0d expected 16", n); end
        set_client(0, 1'b1, 1'b0, 4'd2, 8'h00, 64'h0);
        tick();
        idle_all();
        tick();
        n_cmp++;
        if (resp_valid !== 2'b01 || resp_data !== 64'h0) begin
            n_err++; $display("FAIL clr_zeroed: valid %b data %h expected 01 0", resp_valid, resp_data);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        resetn     = 1'b0;
        clear      = 1'b0;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_strobe = '0;
        req_wdata  = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_read_first();
        test_strobe();
        test_reset_inflight();
        test_clear_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
